// File: rtl/sd_rr_burst_arb.sv
// Round-robin burst arbiter: N srdy/drdy requesters onto one port, up to `burst` beats per grant.
// Latency 0 (1 with SD_RR_ARB_OUTREG_EN output register); p_drdy backpressure holds grant and count.
module sd_rr_burst_arb #(
  parameter int width  = 10,
  parameter int inputs = 4,
  parameter int burst  = 4,
  localparam int gsz   = $clog2(inputs),
  localparam int bsz   = $clog2(burst + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [inputs-1:0]       c_srdy,
  input  logic [inputs*width-1:0] c_data,
  output logic [inputs-1:0]       c_drdy,
  output logic                    p_srdy,
  output logic [width-1:0]        p_data,
  output logic [gsz-1:0]          p_grant,
  input  logic                    p_drdy
);

  typedef enum logic {S_IDLE, S_LOCK} state_t;

  state_t             r_state, w_state_nxt;
  logic [gsz-1:0]     r_gnt, r_rr, w_gnt_nxt, w_rr_nxt, w_win, w_sel;
  logic [bsz-1:0]     r_cnt, w_cnt_nxt;
  logic               w_any, w_vld, w_acc, w_xfer;
  logic [width-1:0]   w_dat;
  logic [inputs-1:0]  w_drdy;

  function automatic logic [gsz-1:0] f_inc(input logic [gsz-1:0] x);
    return (x == gsz'(inputs - 1)) ? '0 : x + 1'b1;
  endfunction

  // First requesting index at or above r_rr, wrapping at inputs-1.
  always_comb begin
    logic [gsz:0] k;
    k     = '0;
    w_win = r_rr;
    w_any = 1'b0;
    for (int i = 0; i < inputs; i++) begin
      k = {1'b0, r_rr} + (gsz+1)'(i);
      if (k >= (gsz+1)'(inputs)) k = k - (gsz+1)'(inputs);
      if (!w_any && c_srdy[k[gsz-1:0]]) begin
        w_win = k[gsz-1:0];
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel  = (r_state == S_LOCK) ? r_gnt : w_win;
    w_vld  = ~reset & ((r_state == S_LOCK) ? c_srdy[r_gnt] : w_any);
    w_xfer = w_vld & w_acc;
    w_dat  = '0;
    for (int i = 0; i < inputs; i++)
      if (w_sel == gsz'(i)) w_dat = c_data[i*width +: width];
    w_drdy        = '0;
    w_drdy[w_sel] = w_xfer;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_cnt   <= '0;
      r_rr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rr    <= w_rr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_cnt_nxt   = r_cnt;
    w_rr_nxt    = r_rr;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          if (burst == 1) begin
            w_rr_nxt = f_inc(w_win);
          end else begin
            w_state_nxt = S_LOCK;
            w_gnt_nxt   = w_win;
            w_cnt_nxt   = bsz'(1);
          end
        end
      end
      S_LOCK: begin
        // A source going idle mid-burst forfeits the rest of its burst.
        if (!c_srdy[r_gnt]) begin
          w_state_nxt = S_IDLE;
          w_rr_nxt    = f_inc(r_gnt);
        end else if (w_xfer) begin
          if (r_cnt == bsz'(burst - 1)) begin
            w_state_nxt = S_IDLE;
            w_rr_nxt    = f_inc(r_gnt);
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef SD_RR_ARB_OUTREG_EN
  logic             r_p_srdy;
  logic [width-1:0] r_p_data;
  logic [gsz-1:0]   r_p_grant;

  assign w_acc = ~r_p_srdy | p_drdy;

  always_ff @(posedge clk) begin
    if (reset)      r_p_srdy <= 1'b0;
    else if (w_acc) r_p_srdy <= w_vld;
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_p_data  <= w_dat;
      r_p_grant <= w_sel;
    end
  end

  always_comb begin
    c_drdy  = w_drdy;
    p_srdy  = r_p_srdy & ~reset;
    p_data  = r_p_data;
    p_grant = r_p_grant;
  end
`else
  assign w_acc = p_drdy;

  always_comb begin
    c_drdy  = w_drdy;
    p_srdy  = w_vld;
    p_data  = w_dat;
    p_grant = w_sel;
  end
`endif

endmodule

// File: tb/tb_sd_rr_burst_arb.sv
// Directed and random stimulus for sd_rr_burst_arb (width 10, 4 inputs, burst 4).
// Per-requester data carries {id, seq}; expected grants are queued as each step is driven.
module tb_sd_rr_burst_arb;

  logic        clk;
  logic        reset;
  logic [3:0]  c_srdy;
  logic [39:0] c_data;
  logic [3:0]  c_drdy;
  logic        p_srdy;
  logic [9:0]  p_data;
  logic [1:0]  p_grant;
  logic        p_drdy;

  sd_rr_burst_arb #(.width(10), .inputs(4), .burst(4)) dut (
    .clk(clk), .reset(reset),
    .c_srdy(c_srdy), .c_data(c_data), .c_drdy(c_drdy),
    .p_srdy(p_srdy), .p_data(p_data), .p_grant(p_grant), .p_drdy(p_drdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] src_seq [4];
  logic [7:0] exp_seq [4];
  int         exp_gnt [$];
  bit         chk_gnt;
  int         n_tests;
  int         n_fail;
  int         n_xfer;

  always_comb begin
    for (int i = 0; i < 4; i++) c_data[i*10 +: 10] = {2'(i), src_seq[i]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at negedge, then advance sources that handshook.
  task automatic tick(input int exp_vld);
    logic [3:0] xf;
    int         g;
    @(negedge clk);
    if (exp_vld >= 0) chk("p_srdy", 32'(p_srdy), 32'(exp_vld));
    if (reset) chk("drdy_in_reset", 32'(c_drdy), 32'd0);
    if (exp_vld == 0) chk("none_served", 32'(c_drdy & c_srdy), 32'd0);
    if (p_srdy) begin
      chk("drdy_sel", 32'(c_drdy[p_grant]), 32'(p_drdy));
      chk("drdy_others", 32'(c_drdy & ~(4'b0001 << p_grant)), 32'd0);
      if (p_drdy) begin
        chk("data_order", 32'(p_data), 32'({p_grant, exp_seq[p_grant]}));
        exp_seq[p_grant] = exp_seq[p_grant] + 8'd1;
        n_xfer++;
        if (chk_gnt) begin
          chk("grant_expected", 32'(exp_gnt.size() != 0), 32'd1);
          if (exp_gnt.size() != 0) begin
            g = exp_gnt.pop_front();
            chk("grant", 32'(p_grant), 32'(g));
          end
        end
      end
    end
    xf = c_srdy & c_drdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (xf[i]) src_seq[i] = src_seq[i] + 8'd1;
  endtask

  task automatic push_gnt(input int g, input int n);
    for (int i = 0; i < n; i++) exp_gnt.push_back(g);
  endtask

  initial begin
    logic [7:0] pat;
    int         x0;
    n_tests = 0;
    n_fail  = 0;
    n_xfer  = 0;
    chk_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      src_seq[i] = 8'd0;
      exp_seq[i] = 8'd0;
    end
    reset  = 1'b1;
    c_srdy = 4'hF;
    p_drdy = 1'b1;
    #1;

    // Reset with everyone requesting: nothing presented, nothing accepted.
    tick(0);
    tick(0);

    // All four streaming: 4-beat bursts in index order, then back to 0.
    reset = 1'b0;
    push_gnt(0, 4); push_gnt(1, 4); push_gnt(2, 4); push_gnt(3, 4); push_gnt(0, 4);
    for (int i = 0; i < 20; i++) tick(1);
    chk("q_drained_stream", 32'(exp_gnt.size()), 32'd0);

    // p_drdy = A5 pattern: burst count advances only on transfers.
    pat = 8'hA5;
    x0  = n_xfer;
    push_gnt(1, 4); push_gnt(2, 4);
    for (int k = 0; k < 16; k++) begin
      p_drdy = pat[k % 8];
      tick(1);
    end
    chk("xfers_a5", 32'(n_xfer - x0), 32'd8);
    chk("q_drained_a5", 32'(exp_gnt.size()), 32'd0);
    p_drdy = 1'b1;
    c_srdy = 4'h0;
    tick(0);

    // Only requester 2: back-to-back beats, bubble only when it drops srdy.
    c_srdy = 4'b0100;
    push_gnt(2, 10);
    for (int i = 0; i < 10; i++) tick(1);
    c_srdy = 4'b0000;
    tick(0);
    c_srdy = 4'b0100;
    push_gnt(2, 1);
    tick(1);
    c_srdy = 4'b0000;
    tick(0);

    // Requester 1 drops after 2 beats while 0 and 3 wait: 3 wins before 0.
    c_srdy = 4'b0010;
    push_gnt(1, 2);
    tick(1);
    c_srdy = 4'b1011;
    tick(1);
    c_srdy = 4'b1001;
    tick(0);
    push_gnt(3, 4); push_gnt(0, 1);
    for (int i = 0; i < 5; i++) tick(1);
    c_srdy = 4'b0000;
    tick(0);
    chk("q_drained_drop", 32'(exp_gnt.size()), 32'd0);

    // Reset after beat 2 of requester 1's burst: restart search from 0.
    c_srdy = 4'b0010;
    push_gnt(1, 2);
    tick(1);
    tick(1);
    reset  = 1'b1;
    c_srdy = 4'hF;
    tick(0);
    tick(0);
    reset = 1'b0;
    push_gnt(0, 4); push_gnt(1, 1);
    for (int i = 0; i < 5; i++) tick(1);
    chk("q_drained_reset", 32'(exp_gnt.size()), 32'd0);

    // Random srdy/drdy: per-requester ordering and handshake rules only.
    chk_gnt = 1'b0;
    x0      = n_xfer;
    for (int i = 0; i < 3000; i++) begin
      c_srdy = 4'($urandom);
      p_drdy = 1'($urandom);
      tick(-1);
    end
    chk("random_progress", 32'(n_xfer - x0 > 100), 32'd1);
    c_srdy = 4'h0;
    tick(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_rr_burst_arb.md
SD_RR_BURST_ARB -- requirements
Module: sd_rr_burst_arb

Interface
REQ-001 Parameter width, default 10: data width of each requester and of the output.
REQ-002 Parameter inputs, default 4: number of requesters, legal range 2..16.
REQ-003 Parameter burst, default 4: maximum consecutive beats per grant, legal range 1..255.
REQ-004 Localparam gsz = $clog2(inputs); localparam bsz = $clog2(burst+1).
REQ-005 clk  input  1  the single clock; all state SHALL change only on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 c_srdy  input  inputs  per-requester source-ready.
REQ-008 c_data  input  inputs*width  requester data, requester i at bits [i*width +: width].
REQ-009 c_drdy  output  inputs  per-requester destination-ready; at most one bit high per cycle.
REQ-010 p_srdy  output  1  output source-ready.
REQ-011 p_data  output  width  output data.
REQ-012 p_grant  output  gsz  index of the requester owning p_data; valid only while p_srdy=1.
REQ-013 A transfer SHALL occur on a port in any cycle where its srdy and drdy are both 1.

Function
REQ-014 The block SHALL have states IDLE and LOCK, a grant register gnt[gsz], a beat counter cnt[bsz] and a round-robin pointer rr[gsz].
REQ-015 In IDLE the winner SHALL be the first requester with c_srdy=1, searching from index rr upward, wrapping from inputs-1 to 0.
REQ-016 In IDLE with any c_srdy=1, the winner's beat SHALL be presented in the same cycle (no arbitration bubble).
REQ-017 In IDLE with all c_srdy=0, p_srdy SHALL be 0 and all c_drdy SHALL be 0.
REQ-018 IDLE transfer with burst=1: the state SHALL stay IDLE and rr SHALL become winner+1 (mod inputs).
REQ-019 IDLE transfer with burst>1: the state SHALL go to LOCK, gnt SHALL become the winner and cnt SHALL become 1.
REQ-020 IDLE with winner present but p_drdy=0: no state change; the winner SHALL be recomputed next cycle, and a higher-priority arrival may preempt it.
REQ-021 In LOCK only requester gnt SHALL be forwarded; c_drdy of all other requesters SHALL be 0.
REQ-022 LOCK transfer with cnt<burst-1: cnt SHALL increment.
REQ-023 LOCK transfer with cnt=burst-1: the state SHALL go to IDLE and rr SHALL become gnt+1 (mod inputs).
REQ-024 LOCK with c_srdy[gnt]=0: p_srdy SHALL be 0, no other requester is served that cycle, the state SHALL go to IDLE and rr SHALL become gnt+1.
REQ-025 LOCK with c_srdy[gnt]=1 and p_drdy=0: hold state, cnt and gnt (backpressure does not count against the burst).
REQ-026 Without the registered output stage, p_srdy, p_data and p_grant SHALL be combinational from the selected requester, and c_drdy[sel] SHALL equal p_drdy.
REQ-027 Data of each requester SHALL leave in the order it was accepted; no beat is dropped or duplicated.
REQ-028 gnt+1 and winner+1 SHALL wrap to 0 when inputs is not a power of two.

Reset
REQ-029 While reset=1: state=IDLE, gnt=0, cnt=0, rr=0, p_srdy=0, c_drdy=0; p_data and p_grant are don't-care.
REQ-030 Reset asserted mid-burst SHALL abandon the burst; the first grant after reset SHALL follow the REQ-015 search from index 0.

Configuration
REQ-031 Macro SD_RR_ARB_OUTREG_EN, when defined, SHALL insert a one-entry output register holding p_srdy, p_data and p_grant.
REQ-032 With SD_RR_ARB_OUTREG_EN defined, the selected requester SHALL see c_drdy = ~p_srdy | p_drdy, latency SHALL be 1 cycle, and full throughput SHALL be kept.
REQ-033 With SD_RR_ARB_OUTREG_EN defined, arbitration SHALL advance on the c-side transfer; in that mode REQ-016..REQ-025 apply with p_drdy replaced by the register-accept term.
REQ-034 Without SD_RR_ARB_OUTREG_EN, output latency SHALL be 0 cycles (fully combinational path).

Verification
REQ-035 Reset release, all four requesters streaming, p_drdy=1, burst=4 -> p_grant sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0...
REQ-036 Only requester 2 active, burst=4 -> continuous beats with p_grant=2 and a one-cycle bubble (p_srdy=0) only if srdy drops; each requester's sequence checked in order.
REQ-037 Requester 1 drops c_srdy after 2 beats while requester 3 waits -> next cycle in IDLE grants 3; requester 0 is not served before 3.
REQ-038 p_drdy pattern 8'hA5 during a burst -> cnt advances only on transfers; exactly 4 beats per grant; no c_drdy high for a non-granted requester.
REQ-039 Reset pulsed after beat 2 of a burst on requester 1 -> c_drdy=0 during reset; first grant after reset goes to requester 0 when all are requesting.
REQ-040 Repeat REQ-035 and REQ-038 with SD_RR_ARB_OUTREG_EN defined -> identical grant order delayed 1 cycle; random srdy/drdy patterns for 10000 cycles with zero sequence errors per requester.
